// File: rtl/serial_twos_decoder.sv
`default_nettype none
// ============================================================================
// Module  : serial_twos_decoder
// Brief   : Collects an LSB-first two's-complement word and presents it as
//           sign-magnitude behind a valid/ready handshake.
// Revision: 1.0  initial release
// ============================================================================
module serial_twos_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_start,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_sign,
  output logic             out_ovf,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    c_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    c_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] c_OVF  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CONV  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           r_state, w_state_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic [WIDTH-1:0] r_word, w_word_n;
  logic [WIDTH-1:0] r_res, w_res_n;
  logic             r_seen, w_seen_n;
  logic             r_out_valid, w_out_valid_n;
  logic [WIDTH-1:0] r_mag, w_mag_n;
  logic             r_sign, w_sign_n;
  logic             r_ovf, w_ovf_n;
  logic             r_frame_err, w_frame_err_n;

  logic             w_accept;
  logic [WIDTH-1:0] w_shift_word;
  logic             w_rbit;
  logic [WIDTH-1:0] w_res_shift;

  assign in_ready  = ~rst & ((r_state == S_IDLE) | (r_state == S_SHIFT));
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_mag   = r_mag;
  assign out_sign  = r_sign;
  assign out_ovf   = r_ovf;
  assign frame_err = r_frame_err;

  // Bits enter at the top and walk down, so after WIDTH accepts bit 0 sits at LSB.
  assign w_shift_word = {in_bit, (in_start ? {(WIDTH-1){1'b0}} : r_word[WIDTH-1:1])};

  // Negation: copy up to and including the first 1, invert everything after it.
  assign w_rbit      = r_seen ? ~r_word[0] : r_word[0];
  assign w_res_shift = {w_rbit, r_res[WIDTH-1:1]};

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_word_n      = r_word;
    w_res_n       = r_res;
    w_seen_n      = r_seen;
    w_out_valid_n = r_out_valid;
    w_mag_n       = r_mag;
    w_sign_n      = r_sign;
    w_ovf_n       = r_ovf;
    w_frame_err_n = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept && in_start) begin
          w_word_n  = w_shift_word;
          w_cnt_n   = c_ONE;
          w_state_n = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (w_accept) begin
          w_word_n = w_shift_word;
          if (in_start) begin
            w_cnt_n       = c_ONE;
            w_frame_err_n = 1'b1;
          end else if (r_cnt == c_LAST) begin
            w_cnt_n = '0;
            if (!in_bit) begin
              w_mag_n   = w_shift_word;
              w_sign_n  = 1'b0;
              w_ovf_n   = 1'b0;
              w_state_n = S_HOLD;
            end else begin
              w_seen_n  = 1'b0;
              w_state_n = S_CONV;
            end
          end else begin
            w_cnt_n = r_cnt + c_ONE;
          end
        end
      end

      S_CONV: begin
        w_word_n = r_word >> 1;
        w_res_n  = w_res_shift;
        w_seen_n = r_seen | r_word[0];
        if (r_cnt == c_LAST) begin
          w_cnt_n   = '0;
          w_mag_n   = w_res_shift;
          w_sign_n  = 1'b1;
          w_ovf_n   = (w_res_shift == c_OVF);
          w_state_n = S_HOLD;
        end else begin
          w_cnt_n = r_cnt + c_ONE;
        end
      end

      S_HOLD: begin
        // out_valid rises one cycle after entry; handshake only once it is visible.
        if (!r_out_valid) begin
          w_out_valid_n = 1'b1;
        end else if (out_ready) begin
          w_out_valid_n = 1'b0;
          w_state_n     = S_IDLE;
        end
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_word      <= '0;
      r_res       <= '0;
      r_seen      <= 1'b0;
      r_out_valid <= 1'b0;
      r_mag       <= '0;
      r_sign      <= 1'b0;
      r_ovf       <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_word      <= w_word_n;
      r_res       <= w_res_n;
      r_seen      <= w_seen_n;
      r_out_valid <= w_out_valid_n;
      r_mag       <= w_mag_n;
      r_sign      <= w_sign_n;
      r_ovf       <= w_ovf_n;
      r_frame_err <= w_frame_err_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_twos_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_twos_decoder
// Brief   : Directed plus random bench for serial_twos_decoder (WIDTH=8).
// Revision: 1.0  initial release
// ============================================================================
module tb_serial_twos_decoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_start, in_bit;
  logic         in_ready, out_valid, out_ready;
  logic [W-1:0] out_mag;
  logic         out_sign, out_ovf, frame_err;

  int n_checks = 0;
  int n_err    = 0;

  serial_twos_decoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_sign  (out_sign),
    .out_ovf   (out_ovf),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the integer value of the word.
  function automatic void model(input int w, output logic [W-1:0] mag,
                                output logic sgn, output logic ovf, output int lat);
    sgn = (w >= (1 << (W - 1)));
    mag = sgn ? W'((1 << W) - w) : W'(w);
    ovf = (w == (1 << (W - 1)));
    lat = sgn ? W + 1 : 1;
  endfunction

  task automatic send_bit(input logic s, input logic b);
    in_valid = 1'b1;
    in_start = s;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic send_word(input int w, input int gap);
    logic [W-1:0] v;
    v = W'(w);
    for (int i = 0; i < W; i++) begin
      send_bit(i == 0, v[i]);
      if (i < W - 1) repeat (gap) tick();
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic expect_result(input string tag, input int w, input int hold);
    logic [W-1:0] e_mag;
    logic         e_sgn, e_ovf;
    int           e_lat, n;
    logic [W-1:0] s_mag;
    model(w, e_mag, e_sgn, e_ovf, e_lat);
    wait_valid(n);
    check({tag, ".latency"}, 32'(n), 32'(e_lat));
    check({tag, ".mag"}, 32'(out_mag), 32'(e_mag));
    check({tag, ".sign"}, 32'(out_sign), 32'(e_sgn));
    check({tag, ".ovf"}, 32'(out_ovf), 32'(e_ovf));
    check({tag, ".in_ready_hold"}, 32'(in_ready), 32'(0));
    s_mag = out_mag;
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        in_valid = 1'($urandom_range(1));
        in_start = 1'($urandom_range(1));
        in_bit   = 1'($urandom_range(1));
        tick();
        check({tag, ".bp_valid"}, 32'(out_valid), 32'(1));
        check({tag, ".bp_mag"}, 32'(out_mag), 32'(s_mag));
        check({tag, ".bp_in_ready"}, 32'(in_ready), 32'(0));
      end
      in_valid  = 1'b0;
      in_start  = 1'b0;
      out_ready = 1'b1;
    end
    tick();
    check({tag, ".valid_drop"}, 32'(out_valid), 32'(0));
    check({tag, ".in_ready_back"}, 32'(in_ready), 32'(1));
    check({tag, ".mag_kept"}, 32'(out_mag), 32'(s_mag));
  endtask

  task automatic decode(input string tag, input int w, input int gap, input int hold);
    out_ready = (hold == 0);
    send_word(w, gap);
    expect_result(tag, w, hold);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(0));
    check({tag, ".mag"}, 32'(out_mag), 32'(0));
    check({tag, ".sign"}, 32'(out_sign), 32'(0));
    check({tag, ".ovf"}, 32'(out_ovf), 32'(0));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(0));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    int w;
    logic [W-1:0] fb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_start  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset.in_ready", 32'(in_ready), 32'(0));
    check("reset.valid", 32'(out_valid), 32'(0));
    check("reset.mag", 32'(out_mag), 32'(0));
    check("reset.frame_err", 32'(frame_err), 32'(0));
    rst = 1'b0;
    #1;
    check("reset.in_ready_after", 32'(in_ready), 32'(1));

    decode("pos5", 8'h05, 0, 0);
    decode("neg5", 8'hFB, 0, 0);
    decode("neg1", 8'hFF, 0, 0);
    decode("min", 8'h80, 0, 0);
    decode("zero", 8'h00, 0, 0);
    decode("max", 8'h7F, 0, 0);
    decode("gap_neg5", 8'hFB, 3, 0);
    decode("gap_min", 8'h80, 3, 0);

    // Bits without in_start in IDLE are discarded.
    for (int k = 0; k < 5; k++) send_bit(1'b0, 1'($urandom_range(1)));
    decode("after_idle_noise", 8'h2C, 0, 0);

    decode("bp", 8'hA7, 0, 5);
    decode("after_bp", 8'h13, 0, 0);

    // Abort after three bits, then a full 0xFB frame.
    out_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    check("abort.no_err_yet", 32'(frame_err), 32'(0));
    fb = 8'hFB;
    send_bit(1'b1, fb[0]);
    check("abort.frame_err", 32'(frame_err), 32'(1));
    send_bit(1'b0, fb[1]);
    check("abort.frame_err_pulse", 32'(frame_err), 32'(0));
    for (int i = 2; i < W; i++) send_bit(1'b0, fb[i]);
    expect_result("abort", 8'hFB, 0);

    // Reset in the fourth CONV cycle.
    send_word(8'hC3, 0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("rst_conv.in_ready_in_rst", 32'(in_ready), 32'(0));
    tick();
    rst = 1'b0;
    #1;
    check_cleared("rst_conv");
    decode("after_rst_conv", 8'h85, 0, 0);

    // Reset while holding a result.
    out_ready = 1'b0;
    send_word(8'h7F, 0);
    begin
      int n;
      wait_valid(n);
      check("rst_hold.valid_seen", 32'(out_valid), 32'(1));
    end
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_cleared("rst_hold");
    decode("after_rst_hold", 8'hFB, 0, 0);

    for (int r = 0; r < 20; r++) begin
      w = int'($urandom_range(255));
      decode("rand", w, int'($urandom_range(3)), (r % 5 == 4) ? 2 : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_twos_decoder.md
# serial_twos_decoder

- Receiving end of the bit-serial two's-complement path.
- Accepts a WIDTH-bit two's-complement word arriving LSB-first, one bit per accepted cycle.
- Converts the word to sign-magnitude, using the same serial negation rule as the stream producer: copy bits up to and including the first 1, then invert.
- Presents the result as a parallel word behind a valid/ready handshake for downstream arithmetic.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  in_bit is valid this cycle.
- in_start  in  1  qualifies in_bit as bit 0 (LSB) of a new word; ignored unless in_valid.
- in_bit  in  1  serial data, LSB first.
- in_ready  out  1  block accepts serial bits. Combinational: 1 in IDLE/SHIFT and rst low.
- out_valid  out  1  parallel result available.
- out_ready  in  1  downstream consumes the result.
- out_mag  out  WIDTH  unsigned magnitude.
- out_sign  out  1  1 = input word was negative.
- out_ovf  out  1  input was -2^(WIDTH-1); out_mag = 2^(WIDTH-1), not representable as a positive signed value.
- frame_err  out  1  one-cycle registered pulse: frame aborted by an early in_start.

## Operation
States: IDLE, SHIFT, CONV, HOLD. A bit is accepted when in_valid && in_ready.

- **IDLE**
  - Accepted bit with in_start: store it as bit 0, cnt=1, go to SHIFT.
  - Accepted bit without in_start: discarded, no error.
- **SHIFT**
  - Each accepted bit is stored at position cnt, then cnt++.
  - in_valid=0 stalls; state and cnt are held.
  - Accepted bit with in_start: abort the partial word, pulse frame_err next cycle, store this bit as bit 0, cnt=1, stay in SHIFT.
  - On accepting bit WIDTH-1 (the sign bit):
    - sign=0: out_mag=word, out_sign=0, out_ovf=0, go to HOLD.
    - sign=1: go to CONV.
- **CONV** (WIDTH cycles; in_ready=0, serial input ignored)
  - Processes one stored bit per cycle, LSB first, with a seen_one flag cleared on CONV entry.
  - Result bit = seen_one ? ~b : b; then seen_one |= b.
  - After WIDTH cycles: out_mag = result, out_sign=1, out_ovf = (result == 1 followed by WIDTH-1 zeros). Go to HOLD.
- **HOLD**
  - out_valid=1; out_mag, out_sign and out_ovf are held stable while out_ready=0.
  - in_ready=0; serial input ignored.
  - out_valid && out_ready: go to IDLE next cycle. out_valid drops; data outputs keep their last value until the next HOLD load.
- Arithmetic: result is modulo 2^WIDTH; no wider intermediate. Input 0 gives out_mag=0, out_sign=0, out_ovf=0.

## Timing
- **Reset**
  - rst high at a clock edge: state=IDLE, cnt=0, seen_one=0, out_valid=0, out_mag=0, out_sign=0, out_ovf=0, frame_err=0.
  - in_ready=0 while rst is high; 1 in the cycle after rst falls.
  - rst has priority over every event, including mid-SHIFT, mid-CONV and a pending handshake in HOLD. Any partial word is discarded with no frame_err.
- **Latency**, measured from the edge accepting the sign bit (edge T):
  - Positive word: out_valid high after edge T+1.
  - Negative word: out_valid high after edge T+1+WIDTH.
- **Throughput**
  - in_ready returns the cycle after the out_valid && out_ready handshake.
  - Minimum word period: WIDTH+2 cycles (positive), 2·WIDTH+2 cycles (negative), with out_ready held high.
- **frame_err**: high exactly one cycle, the cycle after the aborting in_start is accepted.
- in_start on the sign-bit position counts as an abort, not as a word completion.

## Test plan
All with WIDTH=8.

- **+5:** in_start on bit 0, bits 1,0,1,0,0,0,0,0 with out_ready=1 -> out_valid 1 cycle after the last bit; out_mag=0x05, out_sign=0, out_ovf=0; in_ready=1 again the following cycle.
- **-5 (0xFB):** bits 1,1,0,1,1,1,1,1 -> out_valid 9 cycles after the last bit; out_mag=0x05, out_sign=1, out_ovf=0. Then -1 (0xFF) -> out_mag=0x01, out_sign=1.
- **Boundaries:** 0x80 -> out_mag=0x80, out_sign=1, out_ovf=1. 0x00 -> out_mag=0x00, out_sign=0. 0x7F -> out_mag=0x7F, out_sign=0. in_valid gaps of 3 cycles inside a frame give the same results.
- **Backpressure:** out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0. Serial bits driven meanwhile, including in_start, are ignored. out_ready=1 -> IDLE next cycle, and the next frame decodes correctly.
- **Abort:** in_start after 3 bits of a frame -> frame_err pulses for 1 cycle; the new frame 0xFB decodes to out_mag=0x05, out_sign=1.
- **Reset mid-operation:** rst during CONV cycle 4, and separately during HOLD -> next cycle out_valid=0 and all outputs 0. The frame after reset decodes correctly.
